// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues to the icache (hit pushes 2 edges after issue), buffers {pc,instr} for decode.
// Full queue or miss holds the PC; redirect flushes and restarts. FETCH_PERF_EN adds miss/fetch counters.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] icache_address,
    input  logic [31:0] icache_instruction,
    input  logic        icache_hit,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc,
    input  logic        dec_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_miss_cycles,
    output logic [31:0] perf_fetched
`endif
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [63:0]   r_pc;
    state_t        r_state;
    logic [63:0]   r_q_pc    [QDEPTH];
    logic [31:0]   r_q_instr [QDEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_redirect_pc;

    // Full-check uses start-of-cycle occupancy; a same-cycle pop does not make room.
    assign w_full        = (r_count == CW'(QDEPTH));
    assign w_push        = (r_state == ST_CHECK) && icache_hit && !w_full;
    assign w_pop         = (r_count != '0) && dec_ready;
    assign w_redirect_pc = redirect_pc & ~64'h3;

    assign icache_address = r_pc;
    assign dec_valid      = (r_count != '0);
    assign dec_instr      = r_q_instr[r_rd_ptr];
    assign dec_pc         = r_q_pc[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_ISSUE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_state  <= ST_ISSUE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_ISSUE: r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (w_push) begin
                        r_pc    <= r_pc + 64'd4;
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_ISSUE;
            endcase

            if (w_push) begin
                r_q_pc[r_wr_ptr]    <= r_pc;
                r_q_instr[r_wr_ptr] <= icache_instruction;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_fetched;
    logic        w_miss_cycle;
    logic        w_push_taken;

    assign w_miss_cycle = (r_state == ST_CHECK) && !icache_hit && !redirect_valid;
    assign w_push_taken = w_push && !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_miss    <= '0;
            r_perf_fetched <= '0;
        end else begin
            if (w_miss_cycle && (r_perf_miss != 32'hFFFF_FFFF)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (w_push_taken && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
        end
    end

    assign perf_miss_cycles = r_perf_miss;
    assign perf_fetched     = r_perf_fetched;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-level reference model fed by randomized and directed stimulus,
// with a negedge monitor that pops the expected stream on each decode handshake.
module tb_fetch_unit;

    localparam logic [63:0] RPC    = 64'h1000;
    localparam int          QDEPTH = 4;

    logic        clk;
    logic        reset;
    logic [63:0] icache_address;
    logic [31:0] icache_instruction;
    logic        icache_hit;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_fetched;
`endif

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QDEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_address     (icache_address),
        .icache_instruction (icache_instruction),
        .icache_hit         (icache_hit),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .dec_valid          (dec_valid),
        .dec_instr          (dec_instr),
        .dec_pc             (dec_pc),
        .dec_ready          (dec_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_miss_cycles   (perf_miss_cycles),
        .perf_fetched       (perf_fetched)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        exp_q[$];
    logic [63:0] m_pc;
    bit          m_check;
    bit          mon_popped;
    logic [31:0] m_miss;
    logic [31:0] m_fetched;
    logic [63:0] addr_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: an arbitrary function of the address.
    function automatic logic [31:0] imem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc       = RPC;
        m_check    = 1'b0;
        mon_popped = 1'b0;
        m_miss     = '0;
        m_fetched  = '0;
    endtask

    // One clock of the fetch rules: redirect beats everything, issue then check, push only if room.
    task automatic model_step();
        int occ;
        occ = exp_q.size() + (mon_popped ? 1 : 0);
        if (redirect_valid) begin
            exp_q.delete();
            m_pc    = {redirect_pc[63:2], 2'b00};
            m_check = 1'b0;
        end else if (!m_check) begin
            m_check = 1'b1;
        end else if (icache_hit) begin
            if (occ < QDEPTH) begin
                exp_q.push_back('{pc: m_pc, instr: imem(m_pc)});
                m_pc      = m_pc + 64'd4;
                m_check   = 1'b0;
                m_fetched = m_fetched + 32'd1;
            end
        end else begin
            m_miss = m_miss + 32'd1;
        end
        mon_popped = 1'b0;
    endtask

    task automatic drive(input bit h, input bit rdy, input bit rv, input logic [63:0] rpc);
        icache_hit         = h;
        dec_ready          = rdy;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        icache_instruction = imem(addr_q);
    endtask

    task automatic cyc(input bit h, input bit rdy, input bit rv, input logic [63:0] rpc);
        @(posedge clk);
        if (!reset) model_step();
        #1;
        drive(h, rdy, rv, rpc);
    endtask

    // Redirect only once the current cycle is a CHECK cycle.
    task automatic cyc_redir_on_check(input logic [63:0] rpc, output bit fired);
        @(posedge clk);
        if (!reset) model_step();
        #1;
        fired = m_check;
        drive(1'b1, 1'b1, m_check, rpc);
    endtask

    // Cache registers its output: data seen in a cycle belongs to the previous cycle's address.
    always @(negedge clk) addr_q <= icache_address;

    always @(negedge clk) begin
        if (!reset) begin
            chk("icache_address", icache_address, m_pc);
            chk("dec_valid", {63'd0, dec_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("dec_pc", dec_pc, exp_q[0].pc);
                chk("dec_instr", {32'd0, dec_instr}, {32'd0, exp_q[0].instr});
                if (dec_ready) begin
                    void'(exp_q.pop_front());
                    mon_popped = 1'b1;
                end
            end
`ifdef FETCH_PERF_EN
            chk("perf_miss_cycles", {32'd0, perf_miss_cycles}, {32'd0, m_miss});
            chk("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
`endif
        end
    end

    initial begin
        bit fired;
        reset              = 1'b1;
        icache_hit         = 1'b1;
        icache_instruction = '0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        dec_ready          = 1'b1;
        addr_q             = '0;
        model_reset();

        #2;
        chk("reset_address", icache_address, RPC);
        chk("reset_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("reset_dec_pc", dec_pc, 64'd0);
        chk("reset_dec_instr", {32'd0, dec_instr}, 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;

        // Streaming hits from the reset PC.
        repeat (24) cyc(1'b1, 1'b1, 1'b0, 64'd0);

        // Miss hold at 0x2000, then the first hit pushes it.
        cyc(1'b1, 1'b1, 1'b1, 64'h2000);
        repeat (11) cyc(1'b0, 1'b1, 1'b0, 64'd0);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 64'd0);

        // Back-pressure from 0x0 until the queue is full and the PC sits at 0x10.
        cyc(1'b1, 1'b0, 1'b1, 64'h0);
        repeat (16) cyc(1'b1, 1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 64'd0);

        // Flush a partially filled queue with an unaligned target.
        cyc(1'b0, 1'b0, 1'b1, 64'h8003);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 64'd0);

        // Redirect landing on a CHECK hit cycle while decode also pops.
        cyc(1'b1, 1'b0, 1'b1, 64'h3000);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 64'd0);
        fired = 1'b0;
        for (int k = 0; k < 3 && !fired; k++) cyc_redir_on_check(64'h4000, fired);
        chk("collision_redirect_issued", {63'd0, fired}, 64'd1);
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0, {$urandom, $urandom});
        end

        // Asynchronous reset between edges during a miss.
        cyc(1'b0, 1'b1, 1'b1, 64'h5000);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_address", icache_address, RPC);
        chk("async_reset_dec_valid", {63'd0, dec_valid}, 64'd0);
        chk("async_reset_dec_pc", dec_pc, 64'd0);
`ifdef FETCH_PERF_EN
        chk("async_reset_perf_miss", {32'd0, perf_miss_cycles}, 64'd0);
`endif
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 64'd0);
        #2 reset = 1'b0;
        repeat (12) cyc(1'b1, 1'b1, 1'b0, 64'd0);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the instruction cache. It owns the program counter and drives the cache address. It waits out misses while the cache refills from instruction memory. It buffers fetched instructions with their PCs in a small FIFO that feeds decode through a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the new PC.

## Interface

- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be zero.
- QDEPTH, 4, fetch queue entries; power of two, ≥2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- icache_address  out  64  fetch address to instruction cache; equals current PC.
- icache_instruction  in  32  cache instruction output, registered in cache.
- icache_hit  in  1  cache hit, registered in cache; refers to address driven the previous cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  64  redirect target.
- dec_valid  out  1  queue head valid.
- dec_instr  out  32  queue head instruction.
- dec_pc  out  64  queue head PC.
- dec_ready  in  1  decode accepts head this cycle.

## Operation

- Registers:
  - pc (64)
  - FSM state: ISSUE / CHECK
  - queue storage QDEPTH × {pc[63:0], instr[31:0]}
  - rd_ptr, wr_ptr: log2(QDEPTH) bits, wrapping
  - count: log2(QDEPTH)+1 bits
- icache_address = pc, driven continuously from the register.
- ISSUE: pc is presented this cycle; cache outputs are stale and ignored. Go to CHECK unconditionally.
- CHECK:
  - If icache_hit=1 and count<QDEPTH: push {pc, icache_instruction}, pc ← pc+4 (64-bit wrap), go to ISSUE.
  - If icache_hit=1 and queue full: hold pc, stay in CHECK; retry each cycle.
  - If icache_hit=0: miss/refill in progress; hold pc, stay in CHECK.
- Full-check rule: push uses count from the start of the cycle. A simultaneous pop does not free space for that cycle's push.
- Pop: on dec_valid & dec_ready, rd_ptr+1 and count−1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Outputs: dec_valid = (count≠0). dec_instr and dec_pc come from the entry at rd_ptr, combinationally.
- Redirect (redirect_valid=1) has highest priority in any state:
  - pc ← {redirect_pc[63:2], 2'b00}
  - queue flushed: count, rd_ptr, wr_ptr ← 0
  - state ← ISSUE
  - A push in the same cycle is discarded.
  - A pop in the same cycle counts as taken by decode; the queue is still cleared.
- Back-to-back redirects: each restarts ISSUE; the last one wins.
- Sustained throughput on hits: one instruction per 2 cycles.

## Timing

- Reset (async, immediate):
  - pc = RESET_PC, so icache_address = RESET_PC
  - state = ISSUE
  - count = rd_ptr = wr_ptr = 0
  - all queue storage zero
  - dec_valid = 0, dec_instr = 0, dec_pc = 0
- Reset asserted mid-miss or mid-redirect: all of the above is restored; nothing survives.
- Fetch latency, reset deassert to first dec_valid on a hit: the first clock edge enters CHECK, the second edge pushes. dec_valid is high after the 2nd edge.
- Latency after redirect with a hit: dec_valid rises 2 edges after the redirect edge.
- Miss: CHECK holds for as long as icache_hit=0. There is no timeout.
- pc changes only on a push or a redirect edge, so the cache sees a stable address throughout refill.

## Configuration

- FETCH_PERF_EN defined:
  - Adds output ports perf_miss_cycles (32) and perf_fetched (32), both reset to 0.
  - perf_miss_cycles increments on each CHECK cycle with icache_hit=0 and no redirect.
  - perf_fetched increments on each push.
  - Both counters saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan

- Streaming hits: reset with RESET_PC=0x1000, icache_hit held 1, dec_ready=1. Required: dec_pc sequence 0x1000, 0x1004, 0x1008, with a new entry every 2 cycles; dec_instr matches the cache data for each.
- Miss hold: icache_hit=0 for 10 cycles at pc 0x2000. Required: icache_address stays 0x2000 throughout and dec_valid=0; the first hit pushes 0x2000. With FETCH_PERF_EN, perf_miss_cycles=10.
- Back-pressure: dec_ready=0 with hits. Required: count reaches QDEPTH=4 (PCs 0x0–0xC); pc then holds at 0x10 until a pop; no entry is lost or duplicated.
- Redirect flush: queue holds 3 entries, redirect_valid pulses with redirect_pc=0x8003. Required: dec_valid=0 next cycle, icache_address=0x8000, first new entry dec_pc=0x8000.
- Redirect colliding with push and pop: redirect in a CHECK hit cycle with dec_ready=1. Required: the pushed entry is dropped and the queue is empty afterwards.
- Async reset mid-miss: assert reset between clock edges during a miss. Required: icache_address=RESET_PC and dec_valid=0 immediately, before the next edge.
